vec_vsetvl_unit: RTL
====================

VEC_VSETVL_UNIT -- requirements
Module: vec_vsetvl_unit

Interface
REQ-001 SHALL have parameters: XLEN, default 32, scalar width; VLEN, default 512, vector register bits.
REQ-002 SHALL have port: clk  in  1  clock.
REQ-003 SHALL have port: n_rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: inst_valid  in  1  scalar core offers an instruction.
REQ-005 SHALL have port: inst_ready  out  1  unit accepts the instruction.
REQ-006 SHALL have port: inst  in  32  instruction word.
REQ-007 SHALL have port: rs1_data  in  XLEN  rs1 value (AVL).
REQ-008 SHALL have port: rs2_data  in  XLEN  rs2 value (vtype for vsetvl).
REQ-009 SHALL have port: cur_vl  in  XLEN  current vl from the CSR regfile.
REQ-010 SHALL have port: vec_busy  in  1  vector pipeline has in-flight instructions.
REQ-011 SHALL have port: csrwr_en  out  1  one-cycle vtype/vl write strobe to the CSR regfile.
REQ-012 SHALL have port: csr_vl_out  out  XLEN  new vl, driven to the regfile scalar1 input.
REQ-013 SHALL have port: csr_vtype_out  out  XLEN  new vtype, driven to the regfile scalar2 input; bit XLEN-1 = vill, [7]=vma, [6]=vta, [5:3]=vsew, [2:0]=vlmul.
REQ-014 SHALL have port: rd_valid  out  1  rd writeback valid.
REQ-015 SHALL have port: rd_ready  in  1  core accepts the rd writeback.
REQ-016 SHALL have port: rd_addr  out  5  destination register.
REQ-017 SHALL have port: rd_data  out  XLEN  new vl returned to rd.

Function
REQ-018 SHALL decode config instructions as opcode 7'h57 with funct3 3'b111:
  - vsetvli: inst[31]=0; vtype = inst[30:20].
  - vsetivli: inst[31:30]=2'b11; vtype = inst[29:20]; AVL = zero-extended inst[19:15].
  - vsetvl: inst[31:25]=7'b1000000; vtype = rs2_data.
REQ-019 SHALL implement FSM states IDLE, WAIT, COMMIT, RESP.
REQ-020 SHALL assert inst_ready only in IDLE.
REQ-021 On inst_valid && inst_ready with a config instruction, SHALL register inst, rs1_data, rs2_data and cur_vl, then go IDLE->WAIT.
REQ-022 On inst_valid && inst_ready with any other instruction, SHALL stay in IDLE with no output change.
REQ-023 SHALL transition WAIT->COMMIT on the first cycle vec_busy=0.
REQ-024 SHALL assert csrwr_en for exactly one cycle while in COMMIT, with csr_vl_out and csr_vtype_out valid in that cycle.
REQ-025 SHALL leave COMMIT next cycle: to RESP if rd!=0, otherwise to IDLE.
REQ-026 In RESP, SHALL hold rd_valid=1 with rd_addr/rd_data stable until rd_ready=1, then return to IDLE.
REQ-027 Minimum latency SHALL be: accept at cycle 0, csrwr_en at cycle 2, rd_valid at cycle 3.
REQ-028 SHALL compute vlmax = (VLEN << vlmul) >> (3 + vsew) over 10 bits (max 512).
REQ-029 SHALL set vill if any of the following holds: vsew > 3; vlmul in {3'b100..3'b111}; any vtype bit [XLEN-2:8] set. On vill: csr_vtype_out = 1 << (XLEN-1), csr_vl_out = 0, rd_data = 0.
REQ-030 SHALL select AVL as follows:
  - rs1!=0: rs1_data.
  - rs1==0, rd!=0: vlmax.
  - rs1==0, rd==0: captured cur_vl.
  - vsetivli: uimm.
REQ-031 SHALL set vl = min(AVL, vlmax), comparing AVL at full XLEN against zero-extended vlmax; rd_data = vl.
REQ-032 Legal vtype SHALL be output as {vill=0, zeros, vma, vta, vsew, vlmul}.

Reset
REQ-033 On n_rst low, SHALL immediately enter IDLE and clear all outputs:
  - csrwr_en=0, rd_valid=0, inst_ready=1 after release.
  - csr_vl_out=0, csr_vtype_out=0, rd_addr=0, rd_data=0.
REQ-034 Reset in any state, including mid-WAIT or RESP, SHALL abandon the pending instruction with no csrwr_en issued.

Structure
REQ-035 State enum, opcode 7'h57, funct3 constant and vill bit position SHALL reside in the shared vec_de_csr_defs package alongside csr_vtype_s, vlmul_e and vew_e.
REQ-036 SHALL contain one combinational sub-module, vec_vtype_decode (vtype in -> vill, vlmax), instantiated once.

Verification
REQ-037 vsetvli rd=x1, rs1=x5, rs1_data=100, vtype=0x010 (e32,m1) -> csrwr_en 1 cycle, csr_vl_out=16, csr_vtype_out=0x10, rd_data=16.
REQ-038 vsetivli rd=x2, uimm=5, vtype=0x001 (e8,m2) -> vl=5, vlmax=128; rs1_data ignored.
REQ-039 vsetvli rd=x1, rs1=x0, vtype=0x01B (e64,m8) -> vl=64. Same with rd=x0, cur_vl=7 -> vl=7 and no rd_valid.
REQ-040 vsetvl rs2_data=0x20 (vsew=4) -> csr_vtype_out=0x80000000, csr_vl_out=0, rd_data=0.
REQ-041 vec_busy held 3 cycles after accept, then rd_ready low 2 cycles -> csrwr_en at cycle 4, rd_valid held stable until rd_ready; inst_ready=0 throughout.
REQ-042 n_rst pulsed during WAIT -> no csrwr_en, FSM in IDLE, all outputs 0.

Source files
------------

// File: rtl/vec_vsetvl_unit_pkg.sv
// Shared vector CSR definitions: vtype layout, config-instruction decode and
// the vsetvl unit state encoding.
package vec_de_csr_defs;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMMIT,
    ST_RESP
  } vsetvl_state_e;

  typedef enum logic [2:0] {
    LMUL_1, LMUL_2, LMUL_4, LMUL_8, LMUL_RSV, LMUL_F8, LMUL_F4, LMUL_F2
  } vlmul_e;

  typedef enum logic [2:0] {
    SEW_8, SEW_16, SEW_32, SEW_64, SEW_RSV4, SEW_RSV5, SEW_RSV6, SEW_RSV7
  } vew_e;

  typedef struct packed {
    logic   vma;
    logic   vta;
    vew_e   vsew;
    vlmul_e vlmul;
  } csr_vtype_s;

  typedef enum logic [1:0] {
    CFG_NONE,
    CFG_VSETVLI,
    CFG_VSETIVLI,
    CFG_VSETVL
  } cfg_kind_e;

  localparam logic [6:0] OPC_VECTOR = 7'h57;
  localparam logic [2:0] F3_CFG     = 3'b111;

  // vill always occupies the MSB of vtype, whatever the scalar width.
  function automatic int vill_pos(input int xlen);
    return xlen - 1;
  endfunction

  function automatic cfg_kind_e decode_cfg(input logic [31:0] inst);
    cfg_kind_e kind;
    kind = CFG_NONE;
    if (inst[6:0] == OPC_VECTOR && inst[14:12] == F3_CFG) begin
      if (!inst[31])                 kind = CFG_VSETVLI;
      else if (inst[30])             kind = CFG_VSETIVLI;
      else if (inst[29:25] == 5'b0)  kind = CFG_VSETVL;
    end
    return kind;
  endfunction

endpackage

// File: rtl/vec_vsetvl_unit_if.sv
// Core-side bundle of the vsetvl unit: instruction issue, CSR write and rd writeback.
interface vec_vsetvl_unit_if #(
  parameter int XLEN = 32
) ();
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] cur_vl;
  logic            vec_busy;
  logic            csrwr_en;
  logic [XLEN-1:0] csr_vl_out;
  logic [XLEN-1:0] csr_vtype_out;
  logic            rd_valid;
  logic            rd_ready;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;

  modport slave (
    input  inst_valid, inst, rs1_data, rs2_data, cur_vl, vec_busy, rd_ready,
    output inst_ready, csrwr_en, csr_vl_out, csr_vtype_out, rd_valid, rd_addr, rd_data
  );

  modport master (
    output inst_valid, inst, rs1_data, rs2_data, cur_vl, vec_busy, rd_ready,
    input  inst_ready, csrwr_en, csr_vl_out, csr_vtype_out, rd_valid, rd_addr, rd_data
  );
endinterface

// File: rtl/vec_vsetvl_unit_vtype_decode.sv
// Combinational vtype check: flags illegal encodings and derives VLMAX.
module vec_vtype_decode
  import vec_de_csr_defs::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 512
) (
  input  logic [XLEN-2:0] vtype,
  output logic            vill,
  output logic [9:0]      vlmax
);
  csr_vtype_s vt;

  assign vt    = csr_vtype_s'(vtype[7:0]);
  assign vill  = (vt.vsew > SEW_64) || (vt.vlmul > LMUL_8) || (|vtype[XLEN-2:8]);
  // Only integer LMUL reaches here legally, so a left shift covers every legal case.
  assign vlmax = 10'((32'(VLEN) << 3'(vt.vlmul)) >> (4'(vt.vsew) + 4'd3));
endmodule

// File: rtl/vec_vsetvl_unit.sv
// vsetvl/vsetvli/vsetivli execution: waits for the vector pipe to drain, writes
// vtype/vl to the CSR file, then returns the new vl to rd.
module vec_vsetvl_unit
  import vec_de_csr_defs::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 512
) (
  input logic              clk,
  input logic              n_rst,
  vec_vsetvl_unit_if.slave bus
);
  vsetvl_state_e   state_q, state_d;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] rs1_q, cur_vl_q;
  logic [XLEN-2:0] rs2_q;
  cfg_kind_e       kind_q;
  logic [4:0]      rd_idx, rs1_idx;
  logic [XLEN-2:0] vtype_sel;
  csr_vtype_s      vt_legal;
  logic            vill;
  logic [9:0]      vlmax;
  logic [XLEN-1:0] vlmax_x, avl, vl_res, vtype_res;
  logic            accept, ready_c, csrwr_c, rd_valid_c;

  assign accept  = (state_q == ST_IDLE) && bus.inst_valid && (decode_cfg(bus.inst) != CFG_NONE);
  assign kind_q  = decode_cfg(inst_q);
  assign rd_idx  = inst_q[11:7];
  assign rs1_idx = inst_q[19:15];

  // NOTE: operand capture has no reset; it is only read after an accept has loaded it.
  always_ff @(posedge clk) begin
    if (accept) begin
      inst_q   <= bus.inst;
      rs1_q    <= bus.rs1_data;
      rs2_q    <= bus.rs2_data[XLEN-2:0];
      cur_vl_q <= bus.cur_vl;
    end
  end

  vec_vtype_decode #(.XLEN(XLEN), .VLEN(VLEN)) u_vtype_decode (
    .vtype (vtype_sel),
    .vill  (vill),
    .vlmax (vlmax)
  );

  always_comb begin
    case (kind_q)
      CFG_VSETVLI:  vtype_sel = (XLEN-1)'(inst_q[30:20]);
      CFG_VSETIVLI: vtype_sel = (XLEN-1)'(inst_q[29:20]);
      default:      vtype_sel = rs2_q;
    endcase

    vlmax_x = XLEN'(vlmax);
    if (kind_q == CFG_VSETIVLI) avl = XLEN'(rs1_idx);
    else if (rs1_idx != '0)     avl = rs1_q;
    else if (rd_idx != '0)      avl = vlmax_x;
    else                        avl = cur_vl_q;

    vl_res    = (avl < vlmax_x) ? avl : vlmax_x;
    vt_legal  = csr_vtype_s'(vtype_sel[7:0]);
    vtype_res = XLEN'(vt_legal);
    if (vill) begin
      vl_res    = '0;
      vtype_res = XLEN'(1) << vill_pos(XLEN);
    end
  end

  // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Results are latched on the WAIT->COMMIT edge so they are stable in COMMIT and RESP.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.csr_vl_out    <= '0;
      bus.csr_vtype_out <= '0;
      bus.rd_addr       <= '0;
      bus.rd_data       <= '0;
    end else if (state_q == ST_WAIT && !bus.vec_busy) begin
      bus.csr_vl_out    <= vl_res;
      bus.csr_vtype_out <= vtype_res;
      bus.rd_addr       <= rd_idx;
      bus.rd_data       <= vl_res;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ready_c    = 1'b0;
    csrwr_c    = 1'b0;
    rd_valid_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (accept) state_d = ST_WAIT;
      end
      ST_WAIT: if (!bus.vec_busy) state_d = ST_COMMIT;
      ST_COMMIT: begin
        csrwr_c = 1'b1;
        state_d = (rd_idx != '0) ? ST_RESP : ST_IDLE;
      end
      ST_RESP: begin
        rd_valid_c = 1'b1;
        if (bus.rd_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.inst_ready = ready_c;
  assign bus.csrwr_en   = csrwr_c;
  assign bus.rd_valid   = rd_valid_c;
endmodule
